button_debouncer: RTL and testbench

//  Conditions raw, asynchronous push-button/switch inputs before they reach the combinational

---
 rtl/button_debouncer_pkg.sv | 12 +
 rtl/button_debouncer_channel.sv | 52 +++++
 rtl/button_debouncer.sv | 31 +++
 tb/tb_button_debouncer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared debounce constants and the counter-width helper used by every channel.
package button_debouncer_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
    // Board build: 10 ms hold time at a 50 MHz system clock.
    localparam int BOARD_DEBOUNCE_CYCLES   = 500000;

    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced input: 2-FF synchroniser, stability counter, level register and edge pulses.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= RESET_LEVEL;
            s2      <= RESET_LEVEL;
            level_o <= RESET_LEVEL;
            cnt     <= '0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
            if (s2 == level_o) begin
                cnt    <= '0;
                rise_o <= 1'b0;
                fall_o <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                // New value held long enough: commit it and flag the edge.
                level_o <= s2;
                cnt     <= '0;
                rise_o  <= s2;
                fall_o  <= ~s2;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                rise_o <= 1'b0;
                fall_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_CH independent raw button/switch inputs for the gate exercise inputs.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int   N_CH            = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_debouncer_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn_i[g]),
            .level_o (level_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench: directed vector table, hand-built corner sequences, and random
// stimulus compared every cycle against a sample-history reference model.
module tb_button_debouncer;

    localparam int N = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] level_o, rise_o, fall_o;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (D),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o)
    );

    always #5 clk = ~clk;

    // Reference model: history of raw samples taken at each edge. The synchronised
    // value seen at an edge is the sample from two edges earlier; a level flips when
    // the last D synchronised values all differ from the current level.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_level, m_rise, m_fall;

    task automatic model_edge(input logic r, input logic [N-1:0] b);
        logic [N-1:0] s2;
        logic         all_diff;
        m_rise = '0;
        m_fall = '0;
        if (r) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            m_level = '0;
            return;
        end
        s2 = hist[hist.size()-2];
        for (int c = 0; c < N; c++) begin
            all_diff = (hist.size() >= D + 1);
            for (int k = 0; k < D && all_diff; k++)
                if (hist[hist.size()-2-k][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[c] = s2[c];
                m_rise[c]  = s2[c];
                m_fall[c]  = ~s2[c];
            end
        end
        hist.push_back(b);
        while (hist.size() > D + 2) void'(hist.pop_front());
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] b);
        rst = r;
        btn = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        chk("model_level", level_o, m_level);
        chk("model_rise", rise_o, m_rise);
        chk("model_fall", fall_o, m_fall);
        chk("rise_fall_exclusive", rise_o & fall_o, '0);
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] b;
        logic [N-1:0] lvl;
        logic [N-1:0] ris;
        logic [N-1:0] fal;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [N-1:0] b, input logic [N-1:0] lvl,
                       input logic [N-1:0] ris, input logic [N-1:0] fal);
        vec_t v;
        v.r = r; v.b = b; v.lvl = lvl; v.ris = ris; v.fal = fal;
        tbl.push_back(v);
    endtask

    initial begin
        int n_rise;
        int rise_at;

        // Reset with both buttons held, then a clean press on ch0 (edge E = row 3).
        add(1, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) add(0, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00);
        // Three-cycle glitch on ch1 must never reach the level.
        for (int i = 0; i < 3; i++) add(0, 2'b11, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) add(0, 2'b01, 2'b01, 2'b00, 2'b00);
        // Bring ch1 high, then release both together.
        for (int i = 0; i < 5; i++) add(0, 2'b11, 2'b01, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b10, 2'b00);
        add(0, 2'b11, 2'b11, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) add(0, 2'b00, 2'b11, 2'b00, 2'b00);
        add(0, 2'b00, 2'b00, 2'b00, 2'b11);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].b);
            chk($sformatf("vec%0d_level", i), level_o, tbl[i].lvl);
            chk($sformatf("vec%0d_rise", i), rise_o, tbl[i].ris);
            chk($sformatf("vec%0d_fall", i), fall_o, tbl[i].fal);
        end

        // Bounce on ch0: 1,0,1,0,1 then held; one rise, 5 edges after the last toggle.
        n_rise = 0;
        rise_at = -1;
        for (int i = 0; i < 15; i++) begin
            step(0, (i < 5 && (i % 2) == 1) ? 2'b00 : 2'b01);
            if (rise_o[0]) begin
                n_rise++;
                rise_at = i;
            end
        end
        checks++;
        if (n_rise != 1 || rise_at != 9) begin
            errors++;
            $display("FAIL bounce_rise: got %0d pulses at step %0d expected 1 at step 9",
                     n_rise, rise_at);
        end

        // Reset in the middle of a count restarts the full latency.
        step(1, 2'b00);
        for (int i = 0; i < 4; i++) step(0, 2'b01);
        for (int i = 4; i < 6; i++) begin
            step(1, 2'b01);
            chk("midreset_level", level_o, 2'b00);
        end
        rise_at = -1;
        for (int i = 6; i < 15; i++) begin
            step(0, 2'b01);
            if (rise_o[0] && rise_at < 0) rise_at = i;
        end
        checks++;
        if (rise_at != 11) begin
            errors++;
            $display("FAIL midreset_latency: got rise at step %0d expected step 11", rise_at);
        end

        // Random phase: sticky inputs with occasional flips and rare resets.
        begin
            logic [N-1:0] b;
            b = '0;
            for (int i = 0; i < 3000; i++) begin
                for (int c = 0; c < N; c++)
                    if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
                step($urandom_range(0, 199) == 0, b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
